// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit-type constants, arbiter FSM encoding and default flit width
package noc_pkg;

    localparam int DW = 8;

    localparam logic [1:0] FLIT_HEAD   = 2'b10;
    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_TAIL   = 2'b01;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WT   = 2'd2,
        ST_XFER = 2'd3
    } arb_state_t;

    // Tail and single flits both close a packet and release the grant.
    function automatic logic flit_is_last(input logic [1:0] ftype);
        return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority pick: first set request at or after ptr, wrapping
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [2:0]      idx,
    output logic            any
);

    logic found;

    // First pass covers indices at or above ptr; the second pass supplies the wrap to the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (3'(i) >= ptr)) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin arbiter forwarding flits from NREQ source FIFOs to one output
// Optional packet locking (grant held head to tail) is enabled by defining ARB_PKT_LOCK_EN.
module fifo_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = noc_pkg::DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    src_avail,
    input  logic [NREQ*DW-1:0] src_data,
    output logic [NREQ-1:0]    src_read,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [2:0]         grant_id,
    output logic               busy
);

    import noc_pkg::*;

    arb_state_t      state;
    logic [2:0]      rr_ptr;
    logic [2:0]      pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] grant_mask;
    logic            grant_avail;
    logic [DW-1:0]   grant_data;
    logic            last_flit;
    logic [2:0]      next_ptr;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req  (src_avail),
        .ptr  (rr_ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign grant_mask  = NREQ'(1) << grant_id;
    assign grant_avail = |(src_avail & grant_mask);

    // Strobe is a decode of RD and the live avail bit, so it can never fire for an empty FIFO.
    assign src_read = (state == ST_RD) ? (src_avail & grant_mask) : '0;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == 3'(i)) begin
                grant_data = src_data[i*DW +: DW];
            end
        end
    end

`ifdef ARB_PKT_LOCK_EN
    assign last_flit = flit_is_last(out_data[DW-1:DW-2]);
`else
    assign last_flit = 1'b1;
`endif

    assign next_ptr = (grant_id == 3'(NREQ-1)) ? 3'd0 : grant_id + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
                        state    <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (grant_avail) begin
                        state <= ST_WT;
                    end
                end
                // The FIFO presents the popped flit one cycle after the strobe.
                ST_WT: begin
                    out_data  <= grant_data;
                    out_valid <= 1'b1;
                    state     <= ST_XFER;
                end
                ST_XFER: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_flit) begin
                            rr_ptr <= next_ptr;
                            busy   <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of source FIFOs arbitrated, range 2..8.
REQ-002 The block SHALL have parameter DW, default 8: flit width in bits, minimum 3.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port src_avail, input, NREQ bits: bit i high means source FIFO i holds at least one flit.
REQ-006 The block SHALL have port src_data, input, NREQ*DW bits: packed FIFO data_out buses, FIFO i in bits [i*DW +: DW].
REQ-007 The block SHALL have port src_read, output, NREQ bits: one-hot read strobe to the source FIFOs, at most one bit high.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a flit.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the flit this cycle.
REQ-010 The block SHALL have port out_data, output, DW bits: forwarded flit.
REQ-011 The block SHALL have port grant_id, output, 3 bits: index of the current grant holder, valid while busy is high.
REQ-012 The block SHALL have port busy, output, 1 bit: a grant is held.

Function
REQ-013 Flit type SHALL be bits [DW-1:DW-2]: 10 head, 00 body, 01 tail, 11 single-flit packet.
REQ-014 FSM states SHALL be IDLE, RD, WT, XFER.
REQ-015 IDLE: if any src_avail bit is set, the block SHALL grant the first set bit at or after rr_ptr (wrapping NREQ-1 to 0), load grant_id, and go to RD.
REQ-016 RD: if src_avail[grant_id] is set, the block SHALL pulse src_read[grant_id] for exactly one cycle and go to WT; otherwise it SHALL stay in RD with no strobe.
REQ-017 WT: the block SHALL capture src_data[grant_id] into out_data, assert out_valid, and go to XFER. Read-to-valid latency is 2 cycles after the strobe.
REQ-018 XFER: out_valid and out_data SHALL hold stable until out_ready is high; a flit transfers on a cycle where out_valid and out_ready are both high.
REQ-019 On transfer of a tail or single flit, the block SHALL drop out_valid, set rr_ptr to grant_id+1 (mod NREQ), and go to IDLE.
REQ-020 On transfer of a head or body flit, the block SHALL go to RD and keep the same grant.
REQ-021 In IDLE, a source whose front flit is not head or single SHALL still be granted; the block performs no protocol checking.
REQ-022 src_read SHALL never be asserted outside RD, and never for a source whose src_avail bit is low.
REQ-023 When several requests arrive simultaneously, the winner SHALL be the nearest index at or after rr_ptr; a source that waits is served within NREQ packets.

Reset
REQ-024 When rst is low, the block SHALL asynchronously force: state to IDLE, rr_ptr to 0, grant_id to 0, src_read to 0, out_valid to 0, out_data to 0, busy to 0.
REQ-025 Reset asserted mid-packet SHALL abandon the packet; no flit is emitted and the first post-reset grant starts from index 0.

Configuration
REQ-026 With macro ARB_PKT_LOCK_EN defined, the grant SHALL be held from head to tail as in REQ-019 and REQ-020.
REQ-027 Without ARB_PKT_LOCK_EN, every flit SHALL be treated as a tail: the block re-arbitrates and rotates after each transfer.

Structure
REQ-028 A shared package noc_pkg SHALL hold the flit-type constants (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE), the FSM state encoding, and DW.
REQ-029 The rotating-priority pick SHALL be a sub-module, rr_pick: inputs request vector and pointer; outputs winner index and any flag. It is purely combinational.

Verification
REQ-030 Single source, lock on: src_avail=0001, FIFO0 holds 8'h81 then 8'h42, out_ready=1 -> two reads, out_data 8'h81 then 8'h42, returns to IDLE, rr_ptr=1.
REQ-031 Contention: all src_avail=1111, each FIFO holds one single flit 8'hC0+i -> output order C0, C1, C2, C3; src_read is one-hot on every cycle.
REQ-032 Backpressure: out_ready=0 for 5 cycles in XFER -> out_valid stays 1, out_data is unchanged, src_read stays 0.
REQ-033 Lock: FIFO1 sends head/body/tail while FIFO2 requests -> FIFO2 is not read until after the tail from FIFO1; src_avail[1] dropping mid-packet stalls the block in RD.
REQ-034 Without ARB_PKT_LOCK_EN, same stimulus as REQ-033 -> flits from FIFO1 and FIFO2 interleave alternately.
REQ-035 Reset: rst low during XFER -> out_valid=0, busy=0 immediately without waiting for a clock edge; the next grant goes to the lowest requesting index.
